// File: rtl/instr_mem_loader.sv
// Streams instruction words into a single-port memory from address 0, then reads the
// whole memory back through the same port and compares a modulo checksum.
module instr_mem_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              InValid,
    input  logic [DATA_W-1:0] InData,
    output logic              InReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWrData,
    output logic              MemWrEn,
    input  logic [DATA_W-1:0] MemRdData,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [DATA_W-1:0] Checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // The read counter needs one extra bit: VERIFY spans DEPTH+1 cycles (v0..vDEPTH).
    localparam logic [ADDR_W:0]   LAST_RD   = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic [DATA_W-1:0]   rd_sum_q, rd_sum_d;
    logic                error_q, error_d;
    logic [DATA_W-1:0]   rd_sum_next;

    assign rd_sum_next = rd_sum_q + MemRdData;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed by the combinational block.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            checksum_q <= '0;
            rd_sum_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            checksum_q <= checksum_d;
            rd_sum_q   <= rd_sum_d;
            error_q    <= error_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        checksum_d = checksum_q;
        rd_sum_d   = rd_sum_q;
        error_d    = error_q;
        InReady    = 1'b0;
        MemWrEn    = 1'b0;
        MemAddr    = '0;
        Busy       = 1'b0;
        Done       = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                Done = (state_q == S_DONE);
                // Start wins over a simultaneous InValid: no word is taken this cycle.
                if (Start) begin
                    state_d    = S_LOAD;
                    wr_cnt_d   = '0;
                    rd_cnt_d   = '0;
                    checksum_d = '0;
                    rd_sum_d   = '0;
                    error_d    = 1'b0;
                end
            end

            S_LOAD: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                MemAddr = wr_cnt_q;
                MemWrEn = InValid;
                if (InValid) begin
                    checksum_d = checksum_q + InData;
                    if (wr_cnt_q == LAST_ADDR) begin
                        state_d  = S_VERIFY;
                        rd_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end

            S_VERIFY: begin
                Busy    = 1'b1;
                MemAddr = (rd_cnt_q < LAST_RD) ? rd_cnt_q[ADDR_W-1:0] : LAST_ADDR;
                // Read data lags the address by one cycle, so v0 has nothing to add.
                if (rd_cnt_q != '0) begin
                    rd_sum_d = rd_sum_next;
                end
                if (rd_cnt_q == LAST_RD) begin
                    state_d = S_DONE;
                    error_d = (rd_sum_next != checksum_q);
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign MemWrData = InData;
    assign Error     = error_q;
    assign Checksum  = checksum_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a driver queues expected writes and results,
// a negedge monitor pops and compares them against the DUT and a 1-cycle RAM model.
module tb_instr_mem_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_item_t;

    typedef struct packed {
        logic [DATA_W-1:0] checksum;
        logic              error;
    } res_item_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_rd_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] checksum;

    int n_checks = 0;
    int n_fail   = 0;

    wr_item_t  wr_q[$];
    res_item_t res_q[$];
    logic      done_prev = 1'b0;
    bit        corrupt   = 1'b0;

    logic [DATA_W-1:0] mem [DEPTH];

    instr_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk      (clk),
        .Reset    (rst),
        .Start    (start),
        .InValid  (in_valid),
        .InData   (in_data),
        .InReady  (in_ready),
        .MemAddr  (mem_addr),
        .MemWrData(mem_wr_data),
        .MemWrEn  (mem_wr_en),
        .MemRdData(mem_rd_data),
        .Busy     (busy),
        .Done     (done),
        .Error    (error),
        .Checksum (checksum)
    );

    always #5 clk = ~clk;

    // Ideal single-port RAM with registered read; optionally corrupts address 57 on readback.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr] + ((corrupt && mem_addr == 7'd57) ? 16'd1 : 16'd0);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every write and every Done rise must match the next queued expectation.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wr_data);
            end else begin
                wr_item_t w;
                w = wr_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(w.addr));
                check("write_data", 32'(mem_wr_data), 32'(w.data));
            end
        end
        if (done && !done_prev) begin
            if (res_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: checksum 0x%0h, expected no completion", checksum);
            end else begin
                res_item_t r;
                r = res_q.pop_front();
                check("result_checksum", 32'(checksum), 32'(r.checksum));
                check("result_error", 32'(error), 32'(r.error));
            end
        end
        done_prev = done;
    end

    // One program load. pattern: 0 = 1..DEPTH, 1 = all 0xFFFF, 2 = random.
    // gap_mode: 0 = none, 1 = two idle cycles after each word, 2 = random 0..3.
    // abort_after > 0 asserts Reset mid-cycle after that many accepts.
    task automatic run_load(input int pattern, input int gap_mode, input bit corrupt_en,
                            input bit pulse_start, input int abort_after);
        logic [DATA_W-1:0] words [DEPTH];
        logic [DATA_W-1:0] exp_sum;
        logic [DATA_W-1:0] exp_rd_sum;
        int                cyc;
        int                gaps;

        exp_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            case (pattern)
                0:       words[i] = 16'(i + 1);
                1:       words[i] = 16'hFFFF;
                default: words[i] = 16'($urandom);
            endcase
            exp_sum = exp_sum + words[i];
        end
        corrupt = corrupt_en;

        // Start together with a stray InValid: the word must not be accepted.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        #1;
        check("start_cycle_in_ready", 32'(in_ready), 32'd0);
        check("start_cycle_wr_en", 32'(mem_wr_en), 32'd0);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("load_entry_done", 32'(done), 32'd0);
        check("load_entry_checksum", 32'(checksum), 32'd0);
        check("load_entry_busy", 32'(busy), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            start    = pulse_start && (i == 30);
            wr_q.push_back('{addr: ADDR_W'(i), data: words[i]});
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
            if (abort_after > 0 && i + 1 == abort_after) begin
                in_valid = 1'b1;
                #2 rst = 1'b1;
                #1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_in_ready", 32'(in_ready), 32'd0);
                check("abort_wr_en", 32'(mem_wr_en), 32'd0);
                check("abort_checksum", 32'(checksum), 32'd0);
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (i != DEPTH - 1) begin
                gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
                repeat (gaps) begin
                    @(posedge clk); #1;
                end
            end
        end

        // Readback sum the RAM model will deliver, compared against what was written.
        exp_rd_sum = exp_sum + (corrupt_en ? 16'd1 : 16'd0);
        res_q.push_back('{checksum: exp_sum, error: (exp_rd_sum != exp_sum)});

        cyc = 0;
        while (!done && cyc < 400) begin
            start = pulse_start && (cyc == 10);
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check("verify_cycles", 32'(cyc), 32'(DEPTH + 1));

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("done_held", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("checksum_held", 32'(checksum), 32'(exp_sum));
        check("error_held", 32'(error), 32'(exp_rd_sum != exp_sum));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_wr_en", 32'(mem_wr_en), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        check("reset_checksum", 32'(checksum), 32'd0);

        run_load(0, 0, 1'b0, 1'b0, 0);   // words 1..128, back-to-back
        run_load(0, 0, 1'b1, 1'b0, 0);   // readback corruption at address 57
        run_load(0, 1, 1'b0, 1'b0, 0);   // valid pattern 1,0,0,1,...
        run_load(1, 0, 1'b0, 1'b0, 0);   // 0xFFFF wrap
        run_load(0, 0, 1'b0, 1'b0, 50);  // asynchronous abort after 50 accepts
        run_load(0, 0, 1'b0, 1'b0, 0);   // fresh load from IDLE
        run_load(0, 2, 1'b0, 1'b1, 0);   // Start pulsed in LOAD and VERIFY
        run_load(2, 2, 1'b0, 1'b0, 0);   // random data and gaps, started from DONE
        run_load(2, 0, 1'b1, 1'b0, 0);   // random data with corruption

        check("write_queue_drained", 32'(wr_q.size()), 32'd0);
        check("result_queue_drained", 32'(res_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
